// File: rtl/picosoc_wb_master.sv
// Bridges the PicoRV32 native memory interface onto a single-outstanding Wishbone classic
// initiator. A bus timeout keeps the CPU from hanging, and aborted transfers are logged.
module picosoc_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic [7:0]  err_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_tmo_cnt;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_cyc;
  logic        r_err;
  logic [31:0] r_err_addr;
  logic [7:0]  r_err_cnt;

  logic        w_capture;
  logic        w_done;
  logic        w_abort;
  logic        w_tmo_hit;
  logic        w_unused_instr;

  // The fetch qualifier carries no meaning on this bus.
  assign w_unused_instr = mem_instr;
  assign w_tmo_hit      = TMO_EN && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_state_nxt = S_BUS;
      S_BUS:   if (w_done || w_abort) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Error outranks ack; the timeout is only considered when the slave is silent.
  always_comb begin
    w_capture = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: w_capture = mem_valid && !r_ready;
      S_BUS: begin
        if (wb_err_i)       w_abort = 1'b1;
        else if (wb_ack_i)  w_done  = 1'b1;
        else if (w_tmo_hit) w_abort = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_tmo_cnt  <= 16'd0;
      r_ready    <= 1'b0;
      r_rdata    <= 32'd0;
      r_adr      <= 32'd0;
      r_dat      <= 32'd0;
      r_sel      <= 4'd0;
      r_we       <= 1'b0;
      r_cyc      <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= 32'd0;
      r_err_cnt  <= 8'd0;
    end else begin
      r_ready <= w_done || w_abort;
      r_err   <= w_abort;
      if (w_capture) begin
        r_adr     <= mem_addr;
        r_dat     <= mem_wdata;
        r_we      <= |mem_wstrb;
        r_sel     <= (|mem_wstrb) ? mem_wstrb : 4'hF;
        r_cyc     <= 1'b1;
        r_tmo_cnt <= 16'd0;
      end else if (r_state == S_BUS) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
      if (w_done) begin
        r_rdata <= wb_dat_i;
        r_cyc   <= 1'b0;
        r_we    <= 1'b0;
      end
      if (w_abort) begin
        r_rdata    <= ERR_DATA;
        r_err_addr <= r_adr;
        r_err_cnt  <= sat_inc8(r_err_cnt);
        r_cyc      <= 1'b0;
        r_we       <= 1'b0;
      end
    end
  end

  assign mem_ready   = r_ready;
  assign mem_rdata   = r_rdata;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;
  assign wb_sel_o    = r_sel;
  assign wb_we_o     = r_we;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign err_o       = r_err;
  assign err_addr_o  = r_err_addr;
  assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_picosoc_wb_master.sv
// Bench for picosoc_wb_master: directed and randomized transfers against a
// transaction-level model of the bridge (latency, abort rules, error log).
module tb_picosoc_wb_master;

  localparam int          T  = 8;
  localparam logic [31:0] ED = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic [7:0]  err_count_o;

  always #5 clk = ~clk;

  picosoc_wb_master #(.TIMEOUT_CYCLES(T), .ERR_DATA(ED)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .err_o(err_o), .err_addr_o(err_addr_o),
    .err_count_o(err_count_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state and per-transfer expectations
  int          m_err_cnt;
  logic [31:0] m_err_addr;
  logic [31:0] e_rdata;
  logic        e_err;
  int          e_hi;
  logic        e_we;
  logic [3:0]  e_sel;

  // Observations gathered by the transfer driver
  logic        o_cyc1, o_we1, o_stable, o_got, o_err, o_we_resp;
  logic        o_idle_rdy, o_idle_err, o_idle_cyc;
  logic [31:0] o_adr1, o_dat1, o_rdata, o_err_addr;
  logic [3:0]  o_sel1;
  logic [7:0]  o_err_cnt;
  int          o_hi, o_rdy_cycle;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level prediction: the slave answers in BUS cycle resp_at
  // (0 = never); anything later than the timeout window is an abort.
  task automatic predict(input logic [31:0] addr, input logic [3:0] wstrb,
                         input int resp_at, input bit rerr, input logic [31:0] sdata);
    bit ok, ab;
    ok = (resp_at != 0) && (resp_at <= T);
    ab = !ok || rerr;
    e_hi    = ok ? resp_at : T;
    e_we    = (wstrb != 4'd0);
    e_sel   = e_we ? wstrb : 4'hF;
    e_err   = ab;
    e_rdata = ab ? ED : sdata;
    if (ab) begin
      if (m_err_cnt < 255) m_err_cnt++;
      m_err_addr = addr;
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int resp_at,
                      input bit rack, input bit rerr, input logic [31:0] sdata);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_instr = 1'($urandom);
    tick();
    o_cyc1 = wb_cyc_o && wb_stb_o;
    o_adr1 = wb_adr_o;
    o_dat1 = wb_dat_o;
    o_sel1 = wb_sel_o;
    o_we1  = wb_we_o;
    o_stable = 1'b1;
    o_hi = 0;
    o_got = 1'b0;
    o_rdy_cycle = 0;
    for (int n = 1; n <= 200 && !o_got; n++) begin
      if (wb_cyc_o && wb_stb_o) o_hi++;
      if (wb_cyc_o && (wb_adr_o !== o_adr1 || wb_dat_o !== o_dat1 ||
                       wb_sel_o !== o_sel1 || wb_we_o !== o_we1)) o_stable = 1'b0;
      wb_ack_i = rack && (n == resp_at);
      wb_err_i = rerr && (n == resp_at);
      wb_dat_i = (n == resp_at) ? sdata : $urandom;
      // Request-side changes while the transfer is in flight must be ignored
      mem_valid = 1'($urandom);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom);
      tick();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (mem_ready) begin
        o_got = 1'b1;
        o_rdy_cycle = n + 1;
      end
    end
    o_rdata    = mem_rdata;
    o_err      = err_o;
    o_err_addr = err_addr_o;
    o_err_cnt  = err_count_o;
    o_we_resp  = wb_we_o;
    // Stray responses during the completion cycle must have no effect
    mem_valid = 1'b0;
    wb_ack_i  = 1'($urandom);
    wb_err_i  = 1'($urandom);
    wb_dat_i  = $urandom;
    tick();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    o_idle_rdy = mem_ready;
    o_idle_err = err_o;
    o_idle_cyc = wb_cyc_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({mem_ready, err_o, wb_cyc_o, wb_stb_o, wb_we_o} !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {mem_ready, err_o, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    checks++;
    if ({wb_sel_o, wb_adr_o, wb_dat_o} !== 68'd0) begin
      errors++;
      $display("FAIL reset_bus: sel=%h adr=%h dat=%h required 0", wb_sel_o, wb_adr_o, wb_dat_o);
    end
    checks++;
    if ({mem_rdata, err_addr_o, err_count_o} !== 72'd0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h err_addr=%h err_cnt=%0d required 0", mem_rdata, err_addr_o, err_count_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (wb_cyc_o !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: cyc=%b ready=%b required 0 0", wb_cyc_o, mem_ready);
    end
    m_err_cnt = 0;
    m_err_addr = 32'd0;
  endtask

  task automatic test_read();
    predict(32'h100, 4'd0, 2, 1'b0, 32'h12345678);
    xfer(32'h100, $urandom, 4'd0, 2, 1'b1, 1'b0, 32'h12345678);
    checks++;
    if (o_cyc1 !== 1'b1 || o_adr1 !== 32'h100 || o_sel1 !== 4'hF || o_we1 !== 1'b0) begin
      errors++;
      $display("FAIL read_req: cyc=%b adr=%h sel=%h we=%b required 1 00000100 f 0", o_cyc1, o_adr1, o_sel1, o_we1);
    end
    checks++;
    if (o_hi !== 2 || o_rdy_cycle !== 3) begin
      errors++;
      $display("FAIL read_latency: stb_cycles=%0d ready_cycle=%0d required 2 3", o_hi, o_rdy_cycle);
    end
    checks++;
    if (o_rdata !== 32'h12345678 || o_err !== 1'b0 || o_idle_rdy !== 1'b0) begin
      errors++;
      $display("FAIL read_data: rdata=%h err=%b next_ready=%b required 12345678 0 0", o_rdata, o_err, o_idle_rdy);
    end
  endtask

  task automatic test_byte_write();
    predict(32'h204, 4'b0010, 3, 1'b0, 32'h0BADF00D);
    xfer(32'h204, 32'hAABBCCDD, 4'b0010, 3, 1'b1, 1'b0, 32'h0BADF00D);
    checks++;
    if (o_sel1 !== 4'b0010 || o_we1 !== 1'b1 || o_dat1 !== 32'hAABBCCDD || o_stable !== 1'b1) begin
      errors++;
      $display("FAIL write_req: sel=%b we=%b dat=%h stable=%b required 0010 1 aabbccdd 1", o_sel1, o_we1, o_dat1, o_stable);
    end
    checks++;
    if (o_rdy_cycle !== 4 || o_we_resp !== 1'b0 || o_idle_cyc !== 1'b0) begin
      errors++;
      $display("FAIL write_done: ready_cycle=%0d we=%b cyc=%b required 4 0 0", o_rdy_cycle, o_we_resp, o_idle_cyc);
    end
  endtask

  task automatic test_timeout();
    logic seen;
    predict(32'h4000_0010, 4'd0, 0, 1'b0, 32'd0);
    xfer(32'h4000_0010, 32'd0, 4'd0, 0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (o_hi !== T || o_rdy_cycle !== T + 1) begin
      errors++;
      $display("FAIL timeout_len: stb_cycles=%0d ready_cycle=%0d required %0d %0d", o_hi, o_rdy_cycle, T, T + 1);
    end
    checks++;
    if (o_rdata !== ED || o_err !== 1'b1 || o_err_addr !== 32'h4000_0010 || o_err_cnt !== 8'(m_err_cnt)) begin
      errors++;
      $display("FAIL timeout_log: rdata=%h err=%b addr=%h cnt=%0d required %h 1 40000010 %0d", o_rdata, o_err, o_err_addr, o_err_cnt, ED, m_err_cnt);
    end
    checks++;
    if (o_idle_err !== 1'b0 || o_idle_rdy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err=%b ready=%b after one cycle required 0 0", o_idle_err, o_idle_rdy);
    end
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h5555AAAA;
    tick();
    wb_ack_i = 1'b0;
    seen = mem_ready | wb_cyc_o;
    tick();
    seen = seen | mem_ready | wb_cyc_o;
    checks++;
    if (seen !== 1'b0 || mem_rdata !== ED || err_count_o !== 8'(m_err_cnt)) begin
      errors++;
      $display("FAIL late_ack: activity=%b rdata=%h cnt=%0d required 0 %h %0d", seen, mem_rdata, err_count_o, ED, m_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    predict(32'h300, 4'd0, 1, 1'b0, 32'h11111111);
    xfer(32'h300, 32'd0, 4'd0, 1, 1'b1, 1'b0, 32'h11111111);
    checks++;
    if (o_rdata !== 32'h11111111 || o_rdy_cycle !== 2) begin
      errors++;
      $display("FAIL b2b_first: rdata=%h ready_cycle=%0d required 11111111 2", o_rdata, o_rdy_cycle);
    end
    predict(32'h304, 4'd0, 1, 1'b0, 32'h22222222);
    xfer(32'h304, 32'd0, 4'd0, 1, 1'b1, 1'b0, 32'h22222222);
    checks++;
    if (o_cyc1 !== 1'b1 || o_adr1 !== 32'h304 || o_rdata !== 32'h22222222 || o_rdy_cycle !== 2) begin
      errors++;
      $display("FAIL b2b_second: cyc=%b adr=%h rdata=%h ready_cycle=%0d required 1 00000304 22222222 2", o_cyc1, o_adr1, o_rdata, o_rdy_cycle);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, s;
    logic [3:0]  w;
    int          r;
    bit          ka, ke;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      d = $urandom;
      s = $urandom;
      w = (($urandom & 1) != 0) ? 4'd0 : 4'($urandom);
      r = int'($urandom_range(0, 11));
      ka = 1'($urandom);
      ke = (($urandom % 4) == 0);
      if (!ka && !ke) ka = 1'b1;
      predict(a, w, r, ke, s);
      xfer(a, d, w, r, ka, ke, s);
      checks++;
      if (o_cyc1 !== 1'b1 || o_adr1 !== a || o_dat1 !== d || o_sel1 !== e_sel || o_we1 !== e_we || o_stable !== 1'b1) begin
        errors++;
        $display("FAIL rand_req[%0d]: cyc=%b adr=%h dat=%h sel=%h we=%b stable=%b required 1 %h %h %h %b 1", i, o_cyc1, o_adr1, o_dat1, o_sel1, o_we1, o_stable, a, d, e_sel, e_we);
      end
      checks++;
      if (o_got !== 1'b1 || o_hi !== e_hi || o_rdy_cycle !== e_hi + 1) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got=%b stb_cycles=%0d ready_cycle=%0d required 1 %0d %0d", i, o_got, o_hi, o_rdy_cycle, e_hi, e_hi + 1);
      end
      checks++;
      if (o_rdata !== e_rdata || o_err !== e_err || o_err_cnt !== 8'(m_err_cnt) || o_err_addr !== m_err_addr) begin
        errors++;
        $display("FAIL rand_resp[%0d]: rdata=%h err=%b cnt=%0d addr=%h required %h %b %0d %h", i, o_rdata, o_err, o_err_cnt, o_err_addr, e_rdata, e_err, m_err_cnt, m_err_addr);
      end
      checks++;
      if (o_idle_rdy !== 1'b0 || o_idle_err !== 1'b0 || o_idle_cyc !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle[%0d]: ready=%b err=%b cyc=%b required 0 0 0", i, o_idle_rdy, o_idle_err, o_idle_cyc);
      end
    end
  endtask

  task automatic test_err_priority();
    logic [31:0] a;
    predict(32'h800, 4'hF, 3, 1'b1, 32'h13579BDF);
    xfer(32'h800, 32'h01020304, 4'hF, 3, 1'b1, 1'b1, 32'h13579BDF);
    checks++;
    if (o_rdata !== ED || o_err !== 1'b1 || o_hi !== 3 || o_err_cnt !== 8'(m_err_cnt) || o_err_addr !== 32'h800) begin
      errors++;
      $display("FAIL err_priority: rdata=%h err=%b stb_cycles=%0d cnt=%0d addr=%h required %h 1 3 %0d 00000800", o_rdata, o_err, o_hi, o_err_cnt, o_err_addr, ED, m_err_cnt);
    end
    a = 32'd0;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      predict(a, 4'd0, 1, 1'b1, 32'd0);
      xfer(a, 32'd0, 4'd0, 1, 1'b0, 1'b1, 32'd0);
    end
    checks++;
    if (err_count_o !== 8'd255 || m_err_cnt != 255) begin
      errors++;
      $display("FAIL err_saturate: cnt=%0d required 255", err_count_o);
    end
    checks++;
    if (err_addr_o !== a || mem_rdata !== ED) begin
      errors++;
      $display("FAIL err_last: addr=%h rdata=%h required %h %h", err_addr_o, mem_rdata, a, ED);
    end
  endtask

  task automatic test_reset_mid_bus();
    logic seen;
    mem_valid = 1'b1;
    mem_addr  = 32'h900;
    mem_wstrb = 4'd0;
    tick();
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_start: cyc=%b stb=%b required 1 1", wb_cyc_o, wb_stb_o);
    end
    rst_n = 1'b0;
    mem_valid = 1'b0;
    tick();
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || mem_ready !== 1'b0 || err_count_o !== 8'd0) begin
      errors++;
      $display("FAIL midrst_drop: cyc=%b stb=%b ready=%b cnt=%0d required 0 0 0 0", wb_cyc_o, wb_stb_o, mem_ready, err_count_o);
    end
    rst_n = 1'b1;
    m_err_cnt = 0;
    m_err_addr = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_ack_i = 1'($urandom);
      tick();
      seen = seen | mem_ready | wb_cyc_o;
    end
    wb_ack_i = 1'b0;
    checks++;
    if (seen !== 1'b0 || err_count_o !== 8'd0) begin
      errors++;
      $display("FAIL midrst_after: activity=%b cnt=%0d required 0 0", seen, err_count_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_timeout();
    test_back_to_back();
    test_random();
    test_err_priority();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/picosoc_wb_master.md
Name: picosoc_wb_master

Overview:
Bridges the PicoRV32 native memory interface (mem_valid/mem_ready) onto a Wishbone classic single-transfer initiator. It drives the SoC Wishbone bus that the on-chip RAM and peripherals respond to. It issues exactly one outstanding cycle at a time. It has a bus timeout, so an unmapped or stuck slave cannot hang the CPU, and it reports each timeout or bus error.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUS without ack/err before abort; 0 disables timeout; legal range 0..65535
ERR_DATA, 32'hDEADBEEF, value returned on mem_rdata for an aborted/errored transfer

Ports:
wb_clk_i  in  1  system clock, all logic on rising edge
wb_rst_i  in  1  reset, synchronous, active-low
mem_valid  in  1  CPU request valid, held until mem_ready
mem_instr  in  1  instruction fetch qualifier (informational, not forwarded)
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; 0 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
wb_adr_o  out  32  byte address (mem_addr passed unchanged)
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte select
wb_we_o  out  1  write enable
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_dat_i  in  32  slave read data
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error
err_o  out  1  one-cycle pulse per aborted transfer (timeout or wb_err_i)
err_addr_o  out  32  address of most recent aborted transfer
err_count_o  out  8  aborted-transfer count, saturates at 255

Behaviour:
- Reset (wb_rst_i=0 at a rising edge): state IDLE; mem_ready, err_o, wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_sel_o, wb_adr_o, wb_dat_o, mem_rdata, err_addr_o, err_count_o = 0; timeout counter = 0. All outputs are registered.
- FSM states: IDLE, BUS, RESP.
- IDLE: when mem_valid=1 and mem_ready=0, capture the request on the edge:
  - wb_adr_o=mem_addr, wb_dat_o=mem_wdata.
  - wb_we_o=|mem_wstrb; wb_sel_o = mem_wstrb for writes, 4'hF for reads.
  - Set wb_cyc_o=wb_stb_o=1, clear the counter, go to BUS.
- BUS: cyc/stb stay high and the request fields stay stable. The counter increments each cycle. Evaluate in priority order:
  - wb_err_i=1 (even with ack): abort.
  - else wb_ack_i=1: mem_rdata<=wb_dat_i (also captured on writes), drop cyc/stb/we, go to RESP.
  - else TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: abort. cyc/stb are therefore high for exactly TIMEOUT_CYCLES cycles.
  - Abort action: mem_rdata<=ERR_DATA; err_o<=1; err_addr_o<=wb_adr_o; err_count_o increments, saturating at 255; drop cyc/stb/we; go to RESP.
- RESP: mem_ready=1 for exactly one cycle, then IDLE. err_o clears the same cycle mem_ready clears.
- Latency: with request seen in cycle 0 and ack sampled in cycle k (k≥1), mem_ready is high in cycle k+1. A slave that acks one cycle after stb gives 3 cycles from request to ready.
- Back-to-back: a new mem_valid seen in the IDLE cycle after RESP starts immediately. There is no extra idle cycle beyond the RESP state.
- Request changes: deassertion or change of mem_valid/mem_addr while in BUS or RESP is ignored; the captured transfer completes.
- Late responses: wb_ack_i/wb_err_i arriving in IDLE or RESP are ignored, including a late ack after a timeout.
- Reset mid-transfer: cyc/stb drop at the reset edge and no mem_ready is issued.

Test Plan:
- Read: mem_addr=0x100, wstrb=0; slave acks 1 cycle after stb with 0x12345678 -> cyc/stb high 2 cycles, sel=4'hF, we=0, mem_ready in cycle 3 with mem_rdata=0x12345678.
- Byte write: mem_addr=0x204, wdata=0xAABBCCDD, wstrb=4'b0010 -> wb_sel_o=4'b0010, wb_we_o=1, wb_dat_o=0xAABBCCDD held until ack; mem_ready one cycle after ack.
- Timeout: TIMEOUT_CYCLES=8, no ack -> cyc/stb high exactly 8 cycles, then mem_ready with mem_rdata=0xDEADBEEF, err_o pulse, err_addr_o=request address, err_count_o=1; a late ack 3 cycles after abort is ignored.
- Error priority: ack and err asserted together -> treated as abort, mem_rdata=ERR_DATA, err_count_o increments. Repeat 300 errors -> err_count_o=255.
- Back-to-back: a second mem_valid in the cycle after mem_ready -> cyc rises on the next edge with the new address, and no stale data is returned.
- Reset mid-BUS: wb_rst_i=0 while stb is high -> next edge cyc/stb=0, mem_ready never pulses, err_count_o=0.
